// File: rtl/ibex_multdiv_issue.sv
// Issue-side controller for the slow mult/div unit: holds one request stable until the unit answers, then returns the result.
// Optional busy-cycle counter is enabled with `IBEX_MD_ISSUE_PERF_CNT_EN.

package ibex_multdiv_issue_pkg;
  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;
endpackage

module ibex_multdiv_issue
  import ibex_multdiv_issue_pkg::*;
`ifdef IBEX_MD_ISSUE_PERF_CNT_EN
#(
  parameter int unsigned CntWidth = 16
)
`endif
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  md_op_e      req_op_i,
  input  logic [1:0]  req_signed_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic        flush_i,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        mult_sel_o,
  output logic        div_sel_o,
  output md_op_e      operator_o,
  output logic [1:0]  signed_mode_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic        multdiv_ready_id_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  input  logic [33:0] imd_val_d_i [2],
  input  logic [1:0]  imd_val_we_i,
  output logic [33:0] imd_val_q_o [2],
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        busy_o
`ifdef IBEX_MD_ISSUE_PERF_CNT_EN
  ,
  output logic [CntWidth-1:0] busy_cycles_o
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  md_op_e      op_q;
  logic [1:0]  signed_q;
  logic [31:0] a_q, b_q, result_q;
  logic [33:0] imd_q [2];
  logic        accept, is_mul;

  assign accept = (state_q == IDLE) && req_valid_i && !flush_i;
  assign is_mul = (op_q == MD_OP_MULL) || (op_q == MD_OP_MULH);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= MD_OP_MULL;
      signed_q <= 2'b00;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      result_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= req_op_i;
        signed_q <= req_signed_i;
        a_q      <= req_a_i;
        b_q      <= req_b_i;
      end
      if ((state_q == BUSY) && md_valid_i && !flush_i) begin
        result_q <= md_result_i;
      end
    end
  end

  // Intermediate values are written whenever the unit asks, flush or not.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_ni) begin
        imd_q[k] <= 34'h0;
      end else if (imd_val_we_i[k]) begin
        imd_q[k] <= imd_val_d_i[k];
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    req_ready_o        = 1'b0;
    mult_en_o          = 1'b0;
    div_en_o           = 1'b0;
    multdiv_ready_id_o = 1'b0;
    rsp_valid_o        = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = !flush_i;
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        mult_en_o          = is_mul && !flush_i;
        div_en_o           = !is_mul && !flush_i;
        multdiv_ready_id_o = 1'b1;
        if (md_valid_i) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = !flush_i;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  assign mult_sel_o    = mult_en_o;
  assign div_sel_o     = div_en_o;
  assign operator_o    = op_q;
  assign signed_mode_o = signed_q;
  assign op_a_o        = a_q;
  assign op_b_o        = b_q;
  assign rsp_result_o  = result_q;
  assign busy_o        = (state_q != IDLE);
  assign imd_val_q_o   = imd_q;

`ifdef IBEX_MD_ISSUE_PERF_CNT_EN
  logic [CntWidth-1:0] busy_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_cnt_q <= '0;
    end else if ((state_q == BUSY) && (busy_cnt_q != {CntWidth{1'b1}})) begin
      busy_cnt_q <= busy_cnt_q + 1'b1;
    end
  end

  assign busy_cycles_o = busy_cnt_q;
`endif

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Bench for ibex_multdiv_issue: behavioural mult/div unit plus a result scoreboard.
module tb_ibex_multdiv_issue;
  import ibex_multdiv_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid, req_ready, flush;
  md_op_e      req_op;
  logic [1:0]  req_signed;
  logic [31:0] req_a, req_b;
  logic        mult_en, div_en, mult_sel, div_sel, ready_id;
  md_op_e      operator;
  logic [1:0]  signed_mode;
  logic [31:0] op_a, op_b, md_result, rsp_result;
  logic        md_valid, rsp_valid, rsp_ready, busy;
  logic [33:0] imd_d [2];
  logic [33:0] imd_q [2];
  logic [1:0]  imd_we;
`ifdef IBEX_MD_ISSUE_PERF_CNT_EN
  logic [15:0] busy_cycles;
`endif

  always #5 clk = ~clk;

  ibex_multdiv_issue dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_signed_i(req_signed), .req_a_i(req_a), .req_b_i(req_b), .flush_i(flush),
    .mult_en_o(mult_en), .div_en_o(div_en), .mult_sel_o(mult_sel), .div_sel_o(div_sel),
    .operator_o(operator), .signed_mode_o(signed_mode), .op_a_o(op_a), .op_b_o(op_b),
    .multdiv_ready_id_o(ready_id), .md_valid_i(md_valid), .md_result_i(md_result),
    .imd_val_d_i(imd_d), .imd_val_we_i(imd_we), .imd_val_q_o(imd_q),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .busy_o(busy)
`ifdef IBEX_MD_ISSUE_PERF_CNT_EN
    , .busy_cycles_o(busy_cycles)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_result(md_op_e op, logic [1:0] sg, logic [31:0] a, logic [31:0] b);
    logic signed [32:0] ea, eb;
    logic signed [65:0] p;
    logic               sdiv;
    ref_result = 32'h0;
    ea   = $signed({sg[0] & a[31], a});
    eb   = $signed({sg[1] & b[31], b});
    p    = ea * eb;
    sdiv = sg[0] & sg[1];
    case (op)
      MD_OP_MULL: ref_result = p[31:0];
      MD_OP_MULH: ref_result = p[63:32];
      MD_OP_DIV: begin
        if (b == 0) ref_result = 32'hFFFF_FFFF;
        else if (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = a;
        else if (sdiv) ref_result = $signed(a) / $signed(b);
        else ref_result = a / b;
      end
      default: begin
        if (b == 0) ref_result = a;
        else if (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'h0;
        else if (sdiv) ref_result = $signed(a) % $signed(b);
        else ref_result = a % b;
      end
    endcase
  endfunction

  // Behavioural unit: answers on the 4th consecutive enabled cycle.
  int   en_cnt = 0;
  logic stall = 1'b0;
  logic md_force = 1'b0;
  always @(posedge clk) en_cnt <= (mult_en || div_en) ? en_cnt + 1 : 0;
  assign md_valid = ((mult_en || div_en) && en_cnt >= 3 && !stall) || md_force;
  always_comb md_result = ref_result(operator, signed_mode, op_a, op_b);

  logic [31:0] exp_q [$];
  int   mul_en_cnt = 0;
  logic md_hit_prev = 1'b0;

  always @(negedge clk) begin
    if (mult_en) mul_en_cnt++;
    if (md_hit_prev) check("rsp_after_md", rsp_valid, 1);
    md_hit_prev = md_valid && ready_id && !flush && rst_ni;
    if (rst_ni && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else check("rsp_result", rsp_result, exp_q.pop_front());
    end
  end

  task automatic issue(input md_op_e op, input logic [1:0] sg, input logic [31:0] a,
                       input logic [31:0] b, input logic push, input logic [31:0] exp);
    req_valid = 1'b1; req_op = op; req_signed = sg; req_a = a; req_b = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        req_valid = 1'b0;
        return;
      end
    end
    check("req_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 100000; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        @(posedge clk); #1;
        return;
      end
    end
    check("rsp_timeout", 0, 1);
  endtask

  initial begin
    rst_ni = 1'b0; req_valid = 1'b0; req_op = MD_OP_MULL; req_signed = 2'b00;
    req_a = 0; req_b = 0; flush = 1'b0; rsp_ready = 1'b0; imd_we = 2'b00;
    imd_d[0] = 34'h0; imd_d[1] = 34'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_enables", {mult_en, div_en, mult_sel, div_sel, ready_id}, 0);
    check("rst_ops", {operator, signed_mode, op_a, op_b}, 0);
    check("rst_rsp", {rsp_valid, rsp_result, busy}, 0);
    check("rst_imd", {imd_q[0], imd_q[1]}, 0);
    @(posedge clk); #1 rst_ni = 1'b1;

    // MULL 7*6
    rsp_ready = 1'b1; mul_en_cnt = 0;
    issue(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 1'b1, 32'd42);
    wait_rsp();
    check("mull_en_cycles", mul_en_cnt, 4);

    // DIV by zero
    issue(MD_OP_DIV, 2'b11, 32'h64, 32'h0, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    check("div_en", {div_en, div_sel, mult_en, mult_sel}, 4'b1100);
    check("div_operator", operator, MD_OP_DIV);
    check("div_ops", {signed_mode, op_a, op_b}, {2'b11, 32'h64, 32'h0});
    wait_rsp();

    // REM with a stalled response
    rsp_ready = 1'b0;
    issue(MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("rem_hold_valid", rsp_valid, 1);
      check("rem_hold_result", rsp_result, 32'hFFFF_FFFF);
      check("rem_hold_req_ready", req_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("rem_accept_req_ready", req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("req_ready_after_rsp", req_ready, 1);
    @(posedge clk); #1;

    // flush in IDLE blocks a request
    flush = 1'b1; req_valid = 1'b1; req_op = MD_OP_MULL; req_a = 1; req_b = 1;
    @(negedge clk);
    check("idle_flush_ready", req_ready, 0);
    @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("idle_flush_no_accept", busy, 0);
    @(posedge clk); #1;

    // flush in the 2nd BUSY cycle of a MULH, racing md_valid
    issue(MD_OP_MULH, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h0);
    @(posedge clk); #1 flush = 1'b1; md_force = 1'b1;
    @(negedge clk);
    check("flush_enables", {mult_en, mult_sel, div_en, div_sel}, 0);
    check("flush_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1 flush = 1'b0; md_force = 1'b0;
    @(negedge clk);
    check("flush_idle", busy, 0);
    check("flush_no_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    issue(MD_OP_MULL, 2'b00, 32'd3, 32'd3, 1'b1, 32'd9);
    wait_rsp();

    // intermediate registers, then reset mid-BUSY
    issue(MD_OP_MULL, 2'b00, 32'd5, 32'd5, 1'b0, 32'h0);
    imd_we = 2'b11; imd_d[0] = 34'h3_0000_0001; imd_d[1] = 34'h3_0000_0001;
    @(posedge clk); #1 imd_we = 2'b00;
    @(negedge clk);
    check("imd_write_both", {imd_q[0], imd_q[1]}, {34'h3_0000_0001, 34'h3_0000_0001});
    imd_we = 2'b01; imd_d[0] = 34'h5; imd_d[1] = 34'h7;
    @(posedge clk); #1 imd_we = 2'b00;
    @(negedge clk);
    check("imd_write_one", {imd_q[0], imd_q[1]}, {34'h5, 34'h3_0000_0001});
    @(posedge clk); #1 rst_ni = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_enables", {mult_en, div_en, mult_sel, div_sel, ready_id}, 0);
    check("midrst_ops", {operator, signed_mode, op_a, op_b}, 0);
    check("midrst_rsp", {rsp_valid, rsp_result, busy}, 0);
    check("midrst_imd", {imd_q[0], imd_q[1]}, 0);
    @(posedge clk); #1 rst_ni = 1'b1;

`ifdef IBEX_MD_ISSUE_PERF_CNT_EN
    issue(MD_OP_MULL, 2'b00, 32'd2, 32'd3, 1'b1, 32'd6);
    issue(MD_OP_MULL, 2'b00, 32'd4, 32'd5, 1'b1, 32'd20);
    wait_rsp();
    @(negedge clk);
    check("busy_cycles_two", busy_cycles, 16'd8);
    @(posedge clk); #1 stall = 1'b1;
    issue(MD_OP_MULL, 2'b00, 32'd1, 32'd1, 1'b1, 32'd1);
    repeat (65540) @(posedge clk);
    #1;
    @(negedge clk);
    check("busy_cycles_sat", busy_cycles, 16'hFFFF);
    stall = 1'b0;
    wait_rsp();
`endif

    @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ibex_multdiv_issue.md
# ibex_multdiv_issue

Issue-side controller for the slow multiplier/divider unit. It accepts one decoded MUL/DIV request at a time over a valid/ready handshake and holds its operands and control stable on the unit's request interface until the unit signals valid. It also owns the two 34-bit intermediate-value registers the unit reads and writes, captures the result, and returns it to writeback over a second valid/ready handshake.

## Interface
- CntWidth, 16, width of the busy-cycle counter. Used only with `IBEX_MD_ISSUE_PERF_CNT_EN`.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i / req_ready_o  in/out  1  request handshake.
- req_op_i  in  md_op_e  operation: MULL, MULH, DIV or REM.
- req_signed_i  in  2  signed mode. Bit 0 applies to A, bit 1 to B.
- req_a_i, req_b_i  in  32  operands.
- flush_i  in  1  abort of the in-flight operation.
- mult_en_o, div_en_o  out  1  dynamic enables to the unit.
- mult_sel_o, div_sel_o  out  1  static selects to the unit.
- operator_o  out  md_op_e  operator to the unit.
- signed_mode_o  out  2  signed mode to the unit.
- op_a_o, op_b_o  out  32  operands to the unit.
- multdiv_ready_id_o  out  1  result-accept indication to the unit.
- md_valid_i  in  1  the unit's result is valid.
- md_result_i  in  32  the unit's result.
- imd_val_d_i[2]  in  34 each  intermediate-value write data.
- imd_val_we_i  in  2  intermediate-value write enables.
- imd_val_q_o[2]  out  34 each  intermediate-value register contents.
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake.
- rsp_result_o  out  32  response data.
- busy_o  out  1  state is not IDLE.
- busy_cycles_o  out  CntWidth  busy-cycle count. Present only with the macro.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready_o = ~flush_i.
  - On req_valid_i & req_ready_o: capture op, signed mode, A and B into holding registers, then go to BUSY.
- BUSY:
  - mult_en_o = mult_sel_o = (op is MULL or MULH).
  - div_en_o = div_sel_o = (op is DIV or REM).
  - operator_o, signed_mode_o, op_a_o and op_b_o come from the holding registers and stay stable for the whole state.
  - multdiv_ready_id_o = 1.
  - On md_valid_i: capture md_result_i into the result register, then go to RESP.
- RESP:
  - All enables and selects are 0. multdiv_ready_id_o = 0.
  - rsp_valid_o = 1. rsp_result_o is the result register.
  - On rsp_ready_i: go to IDLE.
- In IDLE, all enables and selects are 0. The holding registers keep their last values.
- Flush:
  - flush_i in any state forces IDLE next cycle.
  - In BUSY or RESP, enables and selects drop in the flush cycle itself (combinational gating).
  - Any pending or arriving result is discarded.
- Simultaneous events, in priority order:
  - flush_i beats md_valid_i and beats rsp_ready_i.
  - flush_i in IDLE blocks acceptance of a request.
- Intermediate-value registers:
  - imd_val_q_o[k] <= imd_val_d_i[k] whenever imd_val_we_i[k] = 1, in any state, including during flush.
  - Reset is the only thing that clears them.
  - The two write enables are independent.
- md_valid_i outside BUSY is ignored.

## Timing
- Reset value of every output:
  - req_ready_o = 1 (when flush_i = 0).
  - All of the following are 0: enables, selects, operator_o, signed_mode_o, op_a_o, op_b_o, multdiv_ready_id_o, rsp_valid_o, rsp_result_o, imd_val_q_o, busy_o, busy_cycles_o.
- Reset mid-operation: state returns to IDLE on the next clock edge, and all registers take their reset values.
- Request accepted at edge N: enables are high in cycle N+1.
- md_valid_i sampled high at edge M: rsp_valid_o is high from cycle M+1.
- Response accepted at edge R: req_ready_o is high in cycle R+1. Back-to-back throughput therefore has one idle bubble.
- Added latency through this block: 2 cycles beyond the unit's own latency.
- No combinational path from req_* to the md outputs; all md outputs are registered state plus the flush gating.

## Configuration
- `IBEX_MD_ISSUE_PERF_CNT_EN` defined:
  - busy_cycles_o exists.
  - It increments by 1 on each clock while in BUSY.
  - It saturates at all-ones and is cleared only by reset.
- Undefined: the port and the counter logic are absent.

## Test plan
Bench uses a behavioural unit model that asserts md_valid_i 3 cycles after it first sees an enable, and returns the correct arithmetic result.
- MULL, A=7, B=6, rsp_ready_i=1 → mult_en_o high for 4 cycles; rsp_valid_o with rsp_result_o = 42 exactly one cycle after md_valid_i.
- DIV, A=0x00000064, B=0, signed=2'b11 → div_en_o high, operator_o = DIV; rsp_result_o = 0xFFFFFFFF.
- REM, A=-7, B=2, with rsp_ready_i held low 5 cycles → rsp_valid_o and rsp_result_o = 0xFFFFFFFF held for all 5 cycles; req_ready_o stays 0 until the cycle after acceptance.
- flush_i in the 2nd BUSY cycle of a MULH, with md_valid_i asserted in the same cycle → enables drop that cycle, no rsp_valid_o, IDLE next cycle; the next MULL 3×3 returns 9.
- rst_ni low in mid-BUSY, after imd_val_we_i=2'b11 wrote 34'h3_0000_0001 → all outputs and imd_val_q_o read 0 after the edge.
- With the macro: two back-to-back MULLs → busy_cycles_o = 8. Forced near-max value → busy_cycles_o saturates at 16'hFFFF.
